// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit timing.
// Used by the transmitter today and intended for the receiver as well.
package uart_pkg;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS        = DATA_BITS + 2;
    localparam int CLKS_PER_BIT_DFLT = 5208;   // 50 MHz / 9600 baud

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uart_state_t;

    // Cycles from byte acceptance until the line is back in IDLE.
    function automatic int frame_cycles(input int clks_per_bit);
        return FRAME_BITS * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled,
// pulses tick on the last count of each bit period and is held at 0 when disabled.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst_m,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LP_TC = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_tc;

    assign w_at_tc = (r_cnt == LP_TC);
    assign tick    = en && w_at_tc;

    always_ff @(posedge clk) begin
        if (rst_m || !en) begin
            r_cnt <= '0;
        end else if (w_at_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter: accepts a byte on valid/ready and shifts it out LSB first
// between a start and a stop bit, each bit lasting CLKS_PER_BIT clocks.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   S_IDLE  | line high, ready for a byte (tx_done pulses on entry)
//   S_START | start bit, line low
//   S_DATA  | data bits, line = shift[0], LSB first
//   S_STOP  | stop bit, line high
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_m,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [2:0] LP_LAST_IDX = 3'(DATA_BITS - 1);

    uart_state_t r_state;
    logic [7:0]  r_shift;
    logic [2:0]  r_idx;
    logic        r_txd;
    logic        r_done;

    uart_state_t w_state_nxt;
    logic [7:0]  w_shift_nxt;
    logic [2:0]  w_idx_nxt;
    logic        w_txd_nxt;
    logic        w_done_nxt;
    logic        w_accept;
    logic        w_tick;
    logic        w_baud_en;

    assign w_baud_en = (r_state != S_IDLE);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_m (rst_m),
        .en    (w_baud_en),
        .tick  (w_tick)
    );

    assign tx_ready = (r_state == S_IDLE);
    assign tx_busy  = (r_state != S_IDLE);
    assign txd      = r_txd;
    assign tx_done  = r_done;
    assign w_accept = tx_valid && tx_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = tx_data;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_idx_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    // The last bit leaves the index at 7 rather than wrapping.
                    if (r_idx == LP_LAST_IDX) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Line level is registered from the next state so the pin never glitches.
    always_comb begin
        w_txd_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_txd_nxt = 1'b0;
            S_DATA:  w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_m) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule
